// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise + glitch-filter ps2clk/ps2data, decode
//   11-bit frames (start, 8 data LSB-first, odd parity, stop), buffer good bytes in a
//   show-ahead FIFO, report parity/framing/timeout/overflow as sticky flags.
// Latency: byte is written on the filtered clock fall of the stop bit; rx_complete,
//   count and dout follow one cycle later. The filter adds FILTER_LEN+3 cycles.
// Backpressure: none towards the device; a good byte arriving while full is dropped
//   and raises overflow unless rd_en pops in the same cycle.
// Ports: clk/reset (sync, active-high), rx_en, ps2clk/ps2data (raw async pins),
//   rd_en (pop head), clear_err (clear sticky flags), dout/empty/full/count (FIFO view),
//   rx_complete (write pulse), parity_err/frame_err/overflow (sticky).
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_en,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  input  logic                          rd_en,
  input  logic                          clear_err,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rx_complete,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // ---------------- input conditioning ----------------
  logic [1:0]            clk_sync_q, dat_sync_q;
  logic [FILTER_LEN-1:0] clk_hist_q, dat_hist_q;
  logic                  clk_filt_q, dat_filt_q, clk_prev_q;
  logic                  fall_edge;

  // Everything presets to 1 so an idle bus never looks like a start bit after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_hist_q <= '1;
      dat_hist_q <= '1;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2clk};
      dat_sync_q <= {dat_sync_q[0], ps2data};
      clk_hist_q <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      dat_hist_q <= {dat_hist_q[FILTER_LEN-2:0], dat_sync_q[1]};
      // Filtered level only moves once the whole history window agrees.
      if (&clk_hist_q)       clk_filt_q <= 1'b1;
      else if (~|clk_hist_q) clk_filt_q <= 1'b0;
      if (&dat_hist_q)       dat_filt_q <= 1'b1;
      else if (~|dat_hist_q) dat_filt_q <= 1'b0;
      clk_prev_q <= clk_filt_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_filt_q;

  // ---------------- frame FSM ----------------
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push, set_perr, set_ferr, odd_ok;

  assign odd_ok = ^{shreg_q, par_q};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    to_cnt_d = to_cnt_q;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (!rx_en) begin
      // Disabled: silently drop any partial frame.
      state_d  = S_IDLE;
      bitcnt_d = 3'd0;
      to_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall_edge && !dat_filt_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          if (fall_edge) begin
            shreg_d[bitcnt_q] = dat_filt_q;
            bitcnt_d          = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (fall_edge) begin
            par_d   = dat_filt_q;
            state_d = S_STOP;
          end
        end
        default: begin
          if (fall_edge) begin
            state_d  = S_IDLE;
            set_ferr = ~dat_filt_q;
            set_perr = ~odd_ok;
            push     = dat_filt_q & odd_ok;
          end
        end
      endcase

      // Inter-edge watchdog, only meaningful once a frame has started.
      if (state_q == S_IDLE || fall_edge) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_d = '0;
        state_d  = S_IDLE;
        set_ferr = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      par_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // ---------------- show-ahead FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    dout_q, dout_d;
  logic          full_w, pop, wr_ok, ovf_set;
  logic          rxc_q, perr_q, ferr_q, ovf_q;

  assign full_w  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd_en & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok   = push & (~full_w | pop);
  assign ovf_set = push & full_w & ~pop;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!wr_ok && pop) count_d = count_q - (AW+1)'(1);
    // Registered head: bypass the write data when the new head is the slot being
    // written this cycle; hold the last byte while empty.
    dout_d = dout_q;
    if (count_d != '0) begin
      if (wr_ok && (rd_ptr_d == wr_ptr_q)) dout_d = shreg_q;
      else                                 dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= 8'd0;
      rxc_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rxc_q    <= wr_ok;
      // A new event outranks a simultaneous clear.
      perr_q   <= set_perr | (perr_q & ~clear_err);
      ferr_q   <= set_ferr | (ferr_q & ~clear_err);
      ovf_q    <= ovf_set  | (ovf_q  & ~clear_err);
    end
  end

  assign dout        = dout_q;
  assign empty       = (count_q == '0);
  assign full        = full_w;
  assign count       = count_q;
  assign rx_complete = rxc_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on ps2clk/ps2data with a
//   50-cycle half period; every result is compared against hand-derived values.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rx_en, ps2clk, ps2data, rd_en, clear_err;
  logic [7:0] dout;
  logic       empty, full, rx_complete, parity_err, frame_err, overflow;
  logic [2:0] count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int rxc_cnt  = 0;
  int rxc0;

  ps2_rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .ps2clk(ps2clk), .ps2data(ps2data),
    .rd_en(rd_en), .clear_err(clear_err), .dout(dout), .empty(empty), .full(full),
    .count(count), .rx_complete(rx_complete), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_complete) rxc_cnt <= rxc_cnt + 1;

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends frame bits lo..hi (bit0 = start, bit10 = stop). With pop_at_push set,
  // rd_en is raised for the single cycle in which the stop edge writes the FIFO.
  task automatic send_bits(input logic [10:0] fr, input int lo, input int hi,
                           input bit pop_at_push);
    bit seen = 0;
    for (int i = lo; i <= hi; i++) begin
      ps2data = fr[i];
      cycles(25);
      ps2clk = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        rd_en = pop_at_push && (i == 10) && !seen && dut.push;
        if (rd_en) seen = 1;
      end
      rd_en  = 1'b0;
      ps2clk = 1'b1;
      cycles(25);
    end
    ps2data = 1'b1;
    if (pop_at_push) chk("pop_aligned", 32'(seen), 1);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par,
                                     input logic stop);
    logic p;
    p = ~(^d) ^ bad_par;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    send_bits(mk(d, 1'b0, 1'b1), 0, 10, 1'b0);
    cycles(20);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_clr();
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0; @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rx_en = 1'b1; ps2clk = 1'b1; ps2data = 1'b1;
    rd_en = 1'b0; clear_err = 1'b0;
    cycles(5);
    reset = 1'b0;
    cycles(2);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rxc", 32'(rx_complete), 0);
    chk("rst_flags", {29'd0, parity_err, frame_err, overflow}, 0);

    // 1: good 0x1C
    rxc0 = rxc_cnt;
    send(8'h1C);
    chk("t1_rxc", 32'(rxc_cnt - rxc0), 1);
    chk("t1_dout", 32'(dout), 32'h1C);
    chk("t1_count", 32'(count), 1);
    chk("t1_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    pulse_rd();
    chk("t1_empty", 32'(empty), 1);
    chk("t1_count0", 32'(count), 0);
    chk("t1_dout_hold", 32'(dout), 32'h1C);
    pulse_rd();
    chk("t1_rd_empty", 32'(count), 0);

    // 2: bad parity
    rxc0 = rxc_cnt;
    send_bits(mk(8'h1C, 1'b1, 1'b1), 0, 10, 1'b0);
    cycles(20);
    chk("t2_perr", 32'(parity_err), 1);
    chk("t2_ferr", 32'(frame_err), 0);
    chk("t2_count", 32'(count), 0);
    chk("t2_rxc", 32'(rxc_cnt - rxc0), 0);
    pulse_clr();
    chk("t2_clr", 32'(parity_err), 0);

    // 3: bad stop, then good byte keeps frame_err
    send_bits(mk(8'hF0, 1'b0, 1'b0), 0, 10, 1'b0);
    cycles(20);
    chk("t3_ferr", 32'(frame_err), 1);
    chk("t3_perr", 32'(parity_err), 0);
    chk("t3_count", 32'(count), 0);
    send(8'h5A);
    chk("t3_dout", 32'(dout), 32'h5A);
    chk("t3_count1", 32'(count), 1);
    chk("t3_ferr_sticky", 32'(frame_err), 1);
    pulse_rd();
    pulse_clr();

    // 4: timeout after 4 data bits, then recovery
    send_bits(mk(8'h29, 1'b0, 1'b1), 0, 4, 1'b0);
    cycles(2500);
    chk("t4_ferr", 32'(frame_err), 1);
    chk("t4_count", 32'(count), 0);
    rxc0 = rxc_cnt;
    send(8'h29);
    chk("t4_dout", 32'(dout), 32'h29);
    chk("t4_rxc", 32'(rxc_cnt - rxc0), 1);
    pulse_rd();
    pulse_clr();
    chk("t4_clr", 32'(frame_err), 0);

    // 5: overflow, then full+pop coinciding
    rxc0 = rxc_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("t5_full", 32'(full), 1);
    chk("t5_count", 32'(count), 4);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_rxc", 32'(rxc_cnt - rxc0), 4);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t5_rd%0d", i), 32'(dout), 32'(i));
      pulse_rd();
    end
    chk("t5_empty", 32'(empty), 1);
    pulse_clr();
    chk("t5_ovf_clr", 32'(overflow), 0);
    for (int i = 1; i <= 4; i++) send(8'(i));
    rxc0 = rxc_cnt;
    send_bits(mk(8'h05, 1'b0, 1'b1), 0, 10, 1'b1);
    cycles(20);
    chk("t5b_ovf", 32'(overflow), 0);
    chk("t5b_count", 32'(count), 4);
    chk("t5b_rxc", 32'(rxc_cnt - rxc0), 1);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("t5b_rd%0d", i), 32'(dout), 32'(i));
      pulse_rd();
    end

    // 6a: short low glitches with data low must not start a frame
    ps2data = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2clk = 1'b0; cycles(3);
      ps2clk = 1'b1; cycles(20);
    end
    ps2data = 1'b1;
    cycles(20);
    send(8'h33);
    chk("t6_glitch_dout", 32'(dout), 32'h33);
    chk("t6_glitch_count", 32'(count), 1);
    chk("t6_glitch_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    pulse_rd();

    // 6b: rx_en dropped mid-frame
    rxc0 = rxc_cnt;
    send_bits(mk(8'h44, 1'b0, 1'b1), 0, 3, 1'b0);
    rx_en = 1'b0;
    send_bits(mk(8'h44, 1'b0, 1'b1), 4, 10, 1'b0);
    cycles(20);
    rx_en = 1'b1;
    cycles(5);
    chk("t6_en_count", 32'(count), 0);
    chk("t6_en_rxc", 32'(rxc_cnt - rxc0), 0);
    chk("t6_en_flags", {29'd0, parity_err, frame_err, overflow}, 0);

    // 6c: reset with two bytes held
    send(8'h44);
    send(8'h55);
    chk("t6_pre_count", 32'(count), 2);
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_dout", 32'(dout), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It filters and synchronises the raw ps2clk/ps2data lines and decodes 11-bit frames: start, 8 data bits LSB-first, odd parity, stop. Valid bytes are buffered in a show-ahead FIFO. Parity, framing, timeout and overflow conditions are reported as sticky flags. It sits between the board PS/2 pins and the top-level `main` logic that drives the LEDs and consumes keyboard bytes.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2clk/ps2data changes; must be ≥ 2.
- FIFO_DEPTH, 8: byte entries; power of 2, ≥ 2.
- TIMEOUT_CYCLES, 50000: clk cycles allowed without a filtered ps2clk falling edge while a frame is in progress.

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- rx_en, in, 1: receive enable.
- ps2clk, in, 1: raw PS/2 clock, asynchronous.
- ps2data, in, 1: raw PS/2 data, asynchronous.
- rd_en, in, 1: pop the FIFO head.
- clear_err, in, 1: clear the sticky error flags.
- dout, out, 8: FIFO head byte (show-ahead).
- empty, out, 1: FIFO empty.
- full, out, 1: FIFO full.
- count, out, $clog2(FIFO_DEPTH)+1: number of bytes held.
- rx_complete, out, 1: one-cycle pulse when a byte is written to the FIFO.
- parity_err, out, 1: sticky; a frame had bad parity.
- frame_err, out, 1: sticky; bad stop bit or timeout.
- overflow, out, 1: sticky; a valid byte was dropped because the FIFO was full.

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-high. Every output is forced low except empty=1. So dout=0, full=0, count=0, rx_complete=0, and all error flags are 0. The FSM returns to IDLE, the FIFO pointers go to 0, and the filters preset to 1 (bus idle).
- Input path: each line passes through a 2-FF synchroniser, then a FILTER_LEN-sample glitch filter. The filtered value updates only after FILTER_LEN equal consecutive samples.
- Falling edge: a fall_edge strobe fires for one cycle when filtered ps2clk goes 1→0. All data sampling uses filtered ps2data on the fall_edge cycle.
- FSM IDLE: on fall_edge with data=0 (start bit), go to DATA with bitcnt=0. On fall_edge with data=1, stay in IDLE and flag nothing.
- FSM DATA: on each fall_edge, shift the bit into shreg[bitcnt] (LSB first). After bit 7, go to PARITY.
- FSM PARITY: on fall_edge, latch the parity bit and go to STOP.
- FSM STOP: on fall_edge, evaluate the frame and go to IDLE.
  - Stop bit = 0: set frame_err; no push.
  - Parity wrong (XOR of the 8 data bits and the parity bit ≠ 1): set parity_err; no push. If both stop and parity are bad, set both flags.
  - Otherwise the byte is valid. It is pushed on the same cycle, and rx_complete pulses the next cycle, concurrent with the count update.
- Timeout: in DATA, PARITY or STOP, a cycle counter resets on every fall_edge. When it reaches TIMEOUT_CYCLES, go to IDLE and set frame_err. The counter is held at 0 in IDLE.
- rx_en=0: the FSM is held in IDLE and any partial frame is discarded without a flag. FIFO reads continue to work. Deasserting rx_en mid-frame therefore aborts silently.
- Push with FIFO full and no pop in the same cycle: the byte is dropped and overflow is set.
- Push with FIFO full and rd_en in the same cycle: both happen, count is unchanged, overflow is not set.
- rd_en while empty is ignored. On pop, dout shows the new head on the next cycle; dout keeps its last value while empty.
- Push into an empty FIFO: dout is valid and empty=0 on the cycle after the push.
- Pointers wrap modulo FIFO_DEPTH. full asserts when count == FIFO_DEPTH.
- Sticky flags clear on clear_err. If an error event and clear_err occur in the same cycle, the event wins and the flag reads 1.
- reset asserted mid-frame or with data in the FIFO empties everything on the next edge.

Test Plan:
Bench uses FILTER_LEN=8, FIFO_DEPTH=4, TIMEOUT_CYCLES=2000, and a PS/2 half-period of 50 clk cycles.
1. Send 0x1C: bits 0,0,0,1,1,1,0,0,0 then parity 0, stop 1 → rx_complete single pulse, dout=0x1C, count=1, all error flags 0. Then pulse rd_en → empty=1, count=0.
2. Send 0x1C with parity bit 1 → parity_err=1, count unchanged, no rx_complete. Pulse clear_err → parity_err=0.
3. Send 0xF0 with stop bit 0 → frame_err=1, FIFO untouched. Next, send a valid 0x5A → accepted; frame_err stays 1.
4. Stop ps2clk after 4 data bits for 2500 cycles → frame_err=1, FSM back in IDLE. A following valid 0x29 is received correctly.
5. Send 5 valid bytes 0x01..0x05 with no reads → full=1, count=4, overflow=1, and reads return 0x01..0x04. Then repeat with rd_en coinciding with the 5th push → overflow stays 0.
6. Glitch robustness and reset: 3-cycle low glitches on ps2clk during idle → no frame starts. Deassert rx_en mid-frame → no flags, no push. Assert reset with count=2 → count=0, empty=1, dout=0.
